// File: rtl/draw_board_pkg.sv
// Shared types and colour tables for the playfield renderer.
// Palette index 0 means an empty cell; indices 1..7 select a piece colour.
package draw_board_pkg;

    typedef logic [2:0] color_idx_t;

    localparam logic [11:0] BLANK_COLOR = 12'h000;
    localparam logic [11:0] GRID_COLOR  = 12'h222;

    localparam logic [11:0] PAL_BASE [1:7] = '{
        12'hf00, 12'h00f, 12'hff0, 12'h0ff, 12'hf0f, 12'hf80, 12'hccc
    };

    localparam logic [11:0] PAL_LIGHT [1:7] = '{
        12'hfab, 12'haaf, 12'hffa, 12'haff, 12'hfaf, 12'hfca, 12'hfff
    };

    localparam logic [11:0] PAL_DARK [1:7] = '{
        12'h800, 12'h008, 12'h880, 12'h088, 12'h808, 12'h840, 12'h666
    };

endpackage

// File: rtl/draw_board_board_ram.sv
// Board cell memory: one write port, one registered read port, read-first.
// No reset; the top-level clear engine defines the contents.
module board_ram
    import draw_board_pkg::*;
#(
    parameter int DEPTH = 200,
    parameter int AW    = 8
) (
    input  logic            pclk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  color_idx_t      wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output color_idx_t      rdata
);

    color_idx_t mem [0:DEPTH-1];

    // Non-blocking update of both ports gives the old word on a same-address collision.
    always_ff @(posedge pclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/draw_board.sv
// Renders the COLS x ROWS bevelled Tetris board over the upstream pixel stream (2-cycle latency).
// Optional feature macro: DRAW_BOARD_GRID_EN draws grid lines on empty cells.
module draw_board
    import draw_board_pkg::*;
#(
    parameter int COLS  = 10,
    parameter int ROWS  = 20,
    parameter int CELL  = 35,
    parameter int X_POS = 201,
    parameter int Y_POS = 10,
    parameter int BEVEL = 3
) (
    input  logic                      pclk,
    input  logic                      rst,
    input  logic [10:0]               hcount_in,
    input  logic [10:0]               vcount_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      hblnk_in,
    input  logic                      vblnk_in,
    input  logic [11:0]               rgb_in,
    output logic [10:0]               hcount_out,
    output logic [10:0]               vcount_out,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      hblnk_out,
    output logic                      vblnk_out,
    output logic [11:0]               rgb_out,
    input  logic                      wr_en,
    input  logic [$clog2(COLS)-1:0]   wr_col,
    input  logic [$clog2(ROWS)-1:0]   wr_row,
    input  logic [2:0]                wr_color,
    input  logic                      clr_req,
    output logic                      busy
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int OW    = $clog2(CELL + 1);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);

    localparam logic [10:0]   X_POS_L  = 11'(X_POS);
    localparam logic [10:0]   Y_POS_L  = 11'(Y_POS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW:0]   COLS_L   = (CW + 1)'(COLS);
    localparam logic [RW:0]   ROWS_L   = (RW + 1)'(ROWS);
    localparam logic [OW-1:0] CELL_L   = OW'(CELL);
    localparam logic [OW-1:0] CELL_M1  = OW'(CELL - 1);
    localparam logic [OW-1:0] CELL_BEV = OW'(CELL - BEVEL);
    localparam logic [OW-1:0] BEVEL_L  = OW'(BEVEL);
    localparam logic [AW-1:0] COLS_A   = AW'(COLS);
    localparam logic [AW-1:0] ADDR_LAST = AW'(CELLS - 1);

    logic [CW-1:0] col, col_nx;
    logic [RW-1:0] row, row_nx;
    logic [OW-1:0] hoff, hoff_nx, voff, voff_nx;
    logic          h_in, h_in_nx, v_in, v_in_nx;

    logic [10:0]   hcount_d1, vcount_d1;
    logic          hsync_d1, vsync_d1, hblnk_d1, vblnk_d1;
    logic [11:0]   rgb_d1;

    logic [AW-1:0] clr_addr;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_waddr, ram_raddr;
    color_idx_t    ram_wdata, cell_idx;

    logic          light_px, dark_px, grid_px;
    logic [11:0]   pix;

    // Horizontal cell tracking by counting pixels from the left edge instead of dividing.
    always_comb begin
        col_nx  = col;
        hoff_nx = hoff;
        h_in_nx = h_in;
        if (hcount_in == X_POS_L) begin
            col_nx  = '0;
            hoff_nx = '0;
            h_in_nx = 1'b1;
        end else if (h_in && hoff == CELL_M1) begin
            if (col == COL_LAST) begin
                h_in_nx = 1'b0;
            end else begin
                col_nx  = col + 1'b1;
                hoff_nx = '0;
            end
        end else if (h_in) begin
            hoff_nx = hoff + 1'b1;
        end
    end

    // Vertical tracking advances once per line, at the start of each scanline.
    always_comb begin
        row_nx  = row;
        voff_nx = voff;
        v_in_nx = v_in;
        if (hcount_in == 11'd0) begin
            if (vcount_in == Y_POS_L) begin
                row_nx  = '0;
                voff_nx = '0;
                v_in_nx = 1'b1;
            end else if (v_in && voff == CELL_M1) begin
                if (row == ROW_LAST) begin
                    v_in_nx = 1'b0;
                end else begin
                    row_nx  = row + 1'b1;
                    voff_nx = '0;
                end
            end else if (v_in) begin
                voff_nx = voff + 1'b1;
            end
        end
    end

    assign ram_re    = h_in_nx && v_in_nx;
    assign ram_raddr = AW'(row_nx) * COLS_A + AW'(col_nx);

    // The clear engine owns the write port while busy; external writes are dropped then.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_addr;
        ram_wdata = '0;
        if (busy) begin
            ram_we = 1'b1;
        end else if (wr_en && ({1'b0, wr_col} < COLS_L) && ({1'b0, wr_row} < ROWS_L)) begin
            ram_we    = 1'b1;
            ram_waddr = AW'(wr_row) * COLS_A + AW'(wr_col);
            ram_wdata = wr_color;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b1;
            clr_addr <= '0;
        end else if (busy) begin
            if (clr_addr == ADDR_LAST) begin
                busy <= 1'b0;
            end else begin
                clr_addr <= clr_addr + 1'b1;
            end
        end else if (clr_req) begin
            busy     <= 1'b1;
            clr_addr <= '0;
        end
    end

    board_ram #(
        .DEPTH (CELLS),
        .AW    (AW)
    ) u_board_ram (
        .pclk  (pclk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (cell_idx)
    );

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            hoff      <= '0;
            voff      <= '0;
            h_in      <= 1'b0;
            v_in      <= 1'b0;
            hcount_d1 <= '0;
            vcount_d1 <= '0;
            hsync_d1  <= 1'b0;
            vsync_d1  <= 1'b0;
            hblnk_d1  <= 1'b0;
            vblnk_d1  <= 1'b0;
            rgb_d1    <= '0;
        end else begin
            col       <= col_nx;
            row       <= row_nx;
            hoff      <= hoff_nx;
            voff      <= voff_nx;
            h_in      <= h_in_nx;
            v_in      <= v_in_nx;
            hcount_d1 <= hcount_in;
            vcount_d1 <= vcount_in;
            hsync_d1  <= hsync_in;
            vsync_d1  <= vsync_in;
            hblnk_d1  <= hblnk_in;
            vblnk_d1  <= vblnk_in;
            rgb_d1    <= rgb_in;
        end
    end

    // Light bevel wins over dark where the two triangles meet at a cell corner.
    assign light_px = (hoff < BEVEL_L && voff < CELL_M1 - hoff) ||
                      (voff < BEVEL_L && hoff < CELL_M1 - voff);
    assign dark_px  = (hoff >= CELL_BEV && voff >= CELL_L - hoff) ||
                      (voff >= CELL_BEV && hoff >= CELL_L - voff);

`ifdef DRAW_BOARD_GRID_EN
    assign grid_px = (hoff == '0) || (voff == '0);
`else
    assign grid_px = 1'b0;
`endif

    always_comb begin
        pix = rgb_d1;
        if (hblnk_d1 || vblnk_d1) begin
            pix = BLANK_COLOR;
        end else if (h_in && v_in && cell_idx != '0) begin
            if (light_px) begin
                pix = PAL_LIGHT[cell_idx];
            end else if (dark_px) begin
                pix = PAL_DARK[cell_idx];
            end else begin
                pix = PAL_BASE[cell_idx];
            end
        end else if (h_in && v_in && grid_px) begin
            pix = GRID_COLOR;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_d1;
            vcount_out <= vcount_d1;
            hsync_out  <= hsync_d1;
            vsync_out  <= vsync_d1;
            hblnk_out  <= hblnk_d1;
            vblnk_out  <= vblnk_d1;
            rgb_out    <= pix;
        end
    end

endmodule

// File: tb/tb_draw_board.sv
// Directed self-checking bench for draw_board with default geometry.
// Honours DRAW_BOARD_GRID_EN when computing expected empty-cell pixels.
module tb_draw_board;

    logic        pclk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic        wr_en;
    logic [3:0]  wr_col;
    logic [4:0]  wr_row;
    logic [2:0]  wr_color;
    logic        clr_req;
    logic        busy;

    int checks = 0;
    int fails  = 0;
    int lag_err = 0;
    int cnt;
    int bad;

    logic [11:0] bg = 12'h0f0;
    logic [11:0] cap [0:2047];

    int   prev_h, prev_v;
    logic prev_hs, prev_vs, prev_hb, prev_vb;
    logic prev_valid = 1'b0;

    int         hook_h = -1;
    logic [3:0] hook_col;
    logic [4:0] hook_row;
    logic [2:0] hook_color;

    draw_board dut (
        .pclk       (pclk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out),
        .wr_en      (wr_en),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .wr_color   (wr_color),
        .clr_req    (clr_req),
        .busy       (busy)
    );

    always #5 pclk = ~pclk;

    // Expected colour of a pixel on an empty board cell or outside the grid.
    function automatic logic [11:0] exp_empty(input int h, input int v);
        logic in_grid;
        in_grid = (h >= 201) && (h < 551) && (v >= 10) && (v < 710);
`ifdef DRAW_BOARD_GRID_EN
        if (in_grid && (((h - 201) % 35 == 0) || ((v - 10) % 35 == 0)))
            return 12'h222;
`else
        if (in_grid && 1'b0)
            return 12'h222;
`endif
        return bg;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pixel per clock; captures the output belonging to the previous pixel.
    task automatic step(input int h, input int v, input logic hb, input logic vb);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = hb;
        vblnk_in  = vb;
        hsync_in  = (h < 16);
        vsync_in  = (v < 3);
        rgb_in    = bg;
        if (h == hook_h) begin
            wr_en    = 1'b1;
            wr_col   = hook_col;
            wr_row   = hook_row;
            wr_color = hook_color;
        end else begin
            wr_en = 1'b0;
        end
        @(posedge pclk); #1;
        if (prev_valid) begin
            cap[prev_h] = rgb_out;
            if (hcount_out !== 11'(prev_h) || vcount_out !== 11'(prev_v) ||
                hsync_out !== prev_hs || vsync_out !== prev_vs ||
                hblnk_out !== prev_hb || vblnk_out !== prev_vb)
                lag_err++;
        end
        prev_h = h; prev_v = v; prev_hs = hsync_in; prev_vs = vsync_in;
        prev_hb = hb; prev_vb = vb; prev_valid = 1'b1;
    endtask

    // Walks the frame down to line v, then scans hcount 195..hi on that line.
    task automatic render(input int v, input int hi);
        for (int vv = 0; vv < v; vv++) step(0, vv, 1'b0, 1'b1);
        step(0, v, 1'b0, 1'b0);
        for (int h = 195; h <= hi; h++) step(h, v, 1'b0, 1'b0);
        step(2000, v, 1'b1, 1'b0);
    endtask

    task automatic write_cell(input int c, input int r, input int color);
        wr_en    = 1'b1;
        wr_col   = 4'(c);
        wr_row   = 5'(r);
        wr_color = 3'(color);
        @(posedge pclk); #1;
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        hcount_in = 11'd5; vcount_in = 11'd7;
        hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b0; vblnk_in = 1'b0;
        rgb_in = 12'hfff;
        wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_color = '0; clr_req = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("reset rgb_out", 32'(rgb_out), 32'h0);
        check("reset hcount_out", 32'(hcount_out), 32'h0);
        check("reset vcount_out", 32'(vcount_out), 32'h0);
        check("reset hsync_out", 32'(hsync_out), 32'h0);
        check("reset busy", 32'(busy), 32'h1);

        hcount_in = 11'd2000; vcount_in = 11'd0; hsync_in = 1'b0; vsync_in = 1'b1;
        hblnk_in = 1'b1; rgb_in = bg;
        prev_h = 2000; prev_v = 0; prev_hs = 1'b0; prev_vs = 1'b1; prev_hb = 1'b1; prev_vb = 1'b0;
        rst = 1'b0;
        cnt = 0;
        while (cnt < 1000) begin
            @(posedge pclk); #1;
            cnt++;
            if (!busy) break;
        end
        prev_valid = 1'b1;
        check("power-up clear length", 32'(cnt), 32'd200);

        render(10, 560);
        bad = 0;
        for (int h = 201; h <= 560; h++) if (cap[h] !== exp_empty(h, 10)) bad++;
        check("empty board line 10", 32'(bad), 32'd0);
        render(690, 560);
        bad = 0;
        for (int h = 201; h <= 560; h++) if (cap[h] !== exp_empty(h, 690)) bad++;
        check("empty board line 690", 32'(bad), 32'd0);
        step(2001, 690, 1'b0, 1'b1);
        check("hblank pixel", 32'(cap[2000]), 32'h0);
        step(2002, 690, 1'b0, 1'b0);
        check("vblank pixel", 32'(cap[2001]), 32'h0);

        write_cell(9, 19, 1);
        render(675, 560);
        check("c9r19 top-left light", 32'(cap[516]), 32'hfab);
        render(690, 560);
        check("c9r19 base", 32'(cap[530]), 32'hf00);
        check("c9r19 last column dark", 32'(cap[550]), 32'h800);
        check("right of grid", 32'(cap[551]), 32'(exp_empty(551, 690)));
        render(699, 560);
        check("c9r19 right bevel dark", 32'(cap[549]), 32'h800);

        write_cell(0, 0, 1);
        render(10, 240);
        check("c0r0 corner light", 32'(cap[201]), 32'hfab);
        check("c0r0 top bevel light", 32'(cap[234]), 32'hfab);
        render(11, 240);
        check("c0r0 right bevel dark", 32'(cap[235]), 32'h800);

        write_cell(10, 0, 4);
        render(55, 240);
        check("out-of-range column ignored", 32'(cap[211]), 32'(exp_empty(211, 55)));

        hook_h = 281; hook_col = 4'd2; hook_row = 5'd0; hook_color = 3'd2;
        render(20, 290);
        hook_h = -1;
        check("collision read old", 32'(cap[281]), 32'(exp_empty(281, 20)));
        check("collision next read new", 32'(cap[282]), 32'h00f);
        render(20, 290);
        check("collision cell new", 32'(cap[281]), 32'h00f);

        write_cell(5, 10, 3);
        write_cell(3, 4, 7);
        render(370, 390);
        check("c5r10 base", 32'(cap[386]), 32'hff0);

        clr_req = 1'b1;
        @(posedge pclk); #1;
        clr_req = 1'b0;
        check("busy after clr_req", 32'(busy), 32'h1);
        cnt = 0;
        while (cnt < 1000) begin
            @(posedge pclk); #1;
            cnt++;
            wr_en = 1'b0;
            clr_req = 1'b0;
            if (!busy) break;
            if (cnt == 100) begin
                wr_en = 1'b1; wr_col = 4'd3; wr_row = 5'd3; wr_color = 3'd5;
            end
            if (cnt == 150) clr_req = 1'b1;
        end
        check("clear length with ignored clr_req", 32'(cnt), 32'd200);

        render(690, 560);
        check("cleared c9r19", 32'(cap[530]), 32'(exp_empty(530, 690)));
        render(20, 300);
        check("cleared c0r0", 32'(cap[220]), 32'(exp_empty(220, 20)));
        check("cleared c2r0", 32'(cap[282]), 32'(exp_empty(282, 20)));
        check("grid pixel on empty cell", 32'(cap[236]), 32'(exp_empty(236, 20)));
        render(125, 320);
        check("write during busy ignored", 32'(cap[316]), 32'(exp_empty(316, 125)));
        render(160, 320);
        check("cleared c3r4", 32'(cap[316]), 32'(exp_empty(316, 160)));
        render(370, 390);
        check("cleared c5r10", 32'(cap[386]), 32'(exp_empty(386, 370)));

        check("timing outputs lag 2 cycles", 32'(lag_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
